// File: rtl/reg_transfer_sequencer.sv
// Register-transfer micro-sequencer: turns one MOV/SWAP/PUSH/POP request into
// a sequence of single-cycle bus micro-ops on the shared 16-bit register bus,
// including the memory handshake and stack-pointer step strobes.
module reg_transfer_sequencer #(
  parameter logic [3:0] SCRATCH = 4'd5,  // SWAP temporary register (E)
  parameter logic [3:0] SPSEL   = 4'd6   // stack pointer register select
) (
  input  logic       clk,
  input  logic       r,        // synchronous, active-low reset
  input  logic       start,
  input  logic [1:0] op,
  input  logic [3:0] src,
  input  logic [3:0] dst,
  input  logic       mem_rdy,
  output logic [3:0] rsbo,
  output logic [3:0] rsbi,
  output logic       spoe,
  output logic       mwe,
  output logic       mem_wr,
  output logic       mem_rd,
  output logic       sp_inc,
  output logic       sp_dec,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] OpMov  = 2'd0;
  localparam logic [1:0] OpSwap = 2'd1;
  localparam logic [1:0] OpPush = 2'd2;
  localparam logic [1:0] OpPop  = 2'd3;

  typedef enum logic [3:0] {
    StIdle,
    StMov,
    StSw1,
    StSw2,
    StSw3,
    StPa,
    StPw,
    StPd,
    StOi,
    StOa,
    StOr,
    StDone,
    StErr
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] src_q, dst_q;
  logic       accept;

  // Register selects 1..11 address real registers; 0 and 12..15 do not.
  function automatic logic sel_ok(input logic [3:0] sel);
    return (sel != 4'd0) && (sel <= 4'd11);
  endfunction

  assign accept = (state_q == StIdle) && start;

  // State register and operand latch; operands are captured on every accept.
  always_ff @(posedge clk) begin
    if (!r) begin
      state_q <= StIdle;
      src_q   <= 4'd0;
      dst_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_q <= src;
        dst_q <= dst;
      end
    end
  end

  // Next-state: validate the request at accept, then walk the micro-op sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (op)
            OpMov:  state_d = (sel_ok(src) && sel_ok(dst)) ? StMov : StErr;
            OpSwap: state_d = (sel_ok(src) && sel_ok(dst) &&
                               (src != SCRATCH) && (dst != SCRATCH)) ? StSw1 : StErr;
            OpPush: state_d = (sel_ok(src) && (src != SPSEL)) ? StPa : StErr;
            OpPop:  state_d = (sel_ok(dst) && (dst != SPSEL)) ? StOi : StErr;
            default: state_d = StErr;
          endcase
        end
      end
      StMov:  state_d = StDone;
      StSw1:  state_d = StSw2;
      StSw2:  state_d = StSw3;
      StSw3:  state_d = StDone;
      StPa:   state_d = StPw;
      StPw:   state_d = mem_rdy ? StPd : StPw;
      StPd:   state_d = StDone;
      StOi:   state_d = StOa;
      StOa:   state_d = StOr;
      StOr:   state_d = mem_rdy ? StDone : StOr;
      StDone: state_d = StIdle;
      StErr:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from state and latched operands; only OR looks at mem_rdy.
  always_comb begin
    rsbo   = 4'd0;
    rsbi   = 4'd0;
    spoe   = 1'b0;
    mwe    = 1'b0;
    mem_wr = 1'b0;
    mem_rd = 1'b0;
    sp_inc = 1'b0;
    sp_dec = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    busy   = (state_q != StIdle);
    unique case (state_q)
      StIdle: ;
      StMov: begin
        rsbo = src_q;
        rsbi = dst_q;
      end
      StSw1: begin
        rsbo = src_q;
        rsbi = SCRATCH;
      end
      StSw2: begin
        rsbo = dst_q;
        rsbi = src_q;
      end
      StSw3: begin
        rsbo = SCRATCH;
        rsbi = dst_q;
      end
      StPa: begin
        spoe = 1'b1;
        mwe  = 1'b1;
      end
      StPw: begin
        rsbo   = src_q;
        mem_wr = 1'b1;
      end
      StPd: sp_dec = 1'b1;
      StOi: sp_inc = 1'b1;
      StOa: begin
        spoe = 1'b1;
        mwe  = 1'b1;
      end
      StOr: begin
        mem_rd = 1'b1;
        // Latch only while memory is actually driving the bus.
        if (mem_rdy) rsbi = dst_q;
      end
      StDone: done = 1'b1;
      StErr:  err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Directed bench for reg_transfer_sequencer: steps one clock at a time and
// compares the full output vector against hand-computed values.
module tb_reg_transfer_sequencer;

  logic       clk = 1'b0;
  logic       r;
  logic       start;
  logic [1:0] op;
  logic [3:0] src, dst;
  logic       mem_rdy;
  logic [3:0] rsbo, rsbi;
  logic       spoe, mwe, mem_wr, mem_rd, sp_inc, sp_dec, busy, done, err;

  int checks = 0;
  int errors = 0;

  // Flag bit positions in {spoe,mwe,mem_wr,mem_rd,sp_inc,sp_dec,busy,done,err}
  localparam logic [8:0] FSpoe  = 9'b1_0000_0000;
  localparam logic [8:0] FMwe   = 9'b0_1000_0000;
  localparam logic [8:0] FMemWr = 9'b0_0100_0000;
  localparam logic [8:0] FMemRd = 9'b0_0010_0000;
  localparam logic [8:0] FSpInc = 9'b0_0001_0000;
  localparam logic [8:0] FSpDec = 9'b0_0000_1000;
  localparam logic [8:0] FBusy  = 9'b0_0000_0100;
  localparam logic [8:0] FDone  = 9'b0_0000_0010;
  localparam logic [8:0] FErr   = 9'b0_0000_0001;
  localparam logic [8:0] FNone  = 9'b0_0000_0000;

  reg_transfer_sequencer #(
    .SCRATCH(4'd5),
    .SPSEL  (4'd6)
  ) dut (
    .clk    (clk),
    .r      (r),
    .start  (start),
    .op     (op),
    .src    (src),
    .dst    (dst),
    .mem_rdy(mem_rdy),
    .rsbo   (rsbo),
    .rsbi   (rsbi),
    .spoe   (spoe),
    .mwe    (mwe),
    .mem_wr (mem_wr),
    .mem_rd (mem_rd),
    .sp_inc (sp_inc),
    .sp_dec (sp_dec),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_rsbo,
                            input logic [3:0] e_rsbi, input logic [8:0] e_flags);
    logic [16:0] got, exp;
    got = {rsbo, rsbi, spoe, mwe, mem_wr, mem_rd, sp_inc, sp_dec, busy, done, err};
    exp = {e_rsbo, e_rsbi, e_flags};
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed rsbo/rsbi/flags=%h/%h/%b expected %h/%h/%b", tag,
             got[16:13], got[12:9], got[8:0], exp[16:13], exp[12:9], exp[8:0]);
    end
  endtask

  task automatic request(input logic [1:0] o, input logic [3:0] s, input logic [3:0] d);
    op    = o;
    src   = s;
    dst   = d;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // Reset held with start asserted
    r = 1'b0; start = 1'b1; op = 2'd0; src = 4'd1; dst = 4'd3; mem_rdy = 1'b0;
    step();
    expect_out("rst0", 4'd0, 4'd0, FNone);
    step();
    expect_out("rst1", 4'd0, 4'd0, FNone);
    r = 1'b1; start = 1'b0;
    step();
    expect_out("idle", 4'd0, 4'd0, FNone);

    // MOV 1->3; a second start during MOV/DONE with other operands is ignored
    op = 2'd0; src = 4'd1; dst = 4'd3; start = 1'b1;
    step();
    op = 2'd1; src = 4'd2; dst = 4'd4;
    expect_out("mov_bus", 4'd1, 4'd3, FBusy);
    step();
    expect_out("mov_done", 4'd0, 4'd0, FBusy | FDone);
    start = 1'b0;
    step();
    expect_out("mov_idle", 4'd0, 4'd0, FNone);

    // SWAP 2<->4 through scratch 5
    request(2'd1, 4'd2, 4'd4);
    expect_out("sw1", 4'd2, 4'd5, FBusy);
    step();
    expect_out("sw2", 4'd4, 4'd2, FBusy);
    step();
    expect_out("sw3", 4'd5, 4'd4, FBusy);
    step();
    expect_out("sw_done", 4'd0, 4'd0, FBusy | FDone);
    step();
    expect_out("sw_idle", 4'd0, 4'd0, FNone);

    // SWAP using the scratch register is rejected
    request(2'd1, 4'd5, 4'd4);
    expect_out("sw_err", 4'd0, 4'd0, FBusy | FErr);
    step();
    expect_out("sw_err_idle", 4'd0, 4'd0, FNone);

    // PUSH r3 with two wait states; dst=0 must not matter
    request(2'd2, 4'd3, 4'd0);
    expect_out("pa", 4'd0, 4'd0, FBusy | FSpoe | FMwe);
    step();
    expect_out("pw1", 4'd3, 4'd0, FBusy | FMemWr);
    step();
    expect_out("pw2", 4'd3, 4'd0, FBusy | FMemWr);
    step();
    mem_rdy = 1'b1;
    expect_out("pw3", 4'd3, 4'd0, FBusy | FMemWr);
    step();
    mem_rdy = 1'b0;
    expect_out("pd", 4'd0, 4'd0, FBusy | FSpDec);
    step();
    expect_out("push_done", 4'd0, 4'd0, FBusy | FDone);
    step();
    expect_out("push_idle", 4'd0, 4'd0, FNone);

    // POP into r9, memory ready at first OR cycle (mem_rdy high throughout)
    mem_rdy = 1'b1;
    request(2'd3, 4'd0, 4'd9);
    expect_out("oi", 4'd0, 4'd0, FBusy | FSpInc);
    step();
    expect_out("oa", 4'd0, 4'd0, FBusy | FSpoe | FMwe);
    step();
    expect_out("or", 4'd0, 4'd9, FBusy | FMemRd);
    step();
    expect_out("pop_done", 4'd0, 4'd0, FBusy | FDone);
    step();
    mem_rdy = 1'b0;
    expect_out("pop_idle", 4'd0, 4'd0, FNone);

    // POP into r7 with one wait state: rsbi only while mem_rdy is high
    request(2'd3, 4'd9, 4'd7);
    step();
    step();
    expect_out("or_wait", 4'd0, 4'd0, FBusy | FMemRd);
    mem_rdy = 1'b1;
    #1;
    expect_out("or_rdy", 4'd0, 4'd7, FBusy | FMemRd);
    step();
    mem_rdy = 1'b0;
    expect_out("pop2_done", 4'd0, 4'd0, FBusy | FDone);
    step();

    // Rejections: PUSH of SP, POP to 12, MOV to 0
    request(2'd2, 4'd6, 4'd1);
    expect_out("push_sp_err", 4'd0, 4'd0, FBusy | FErr);
    step();
    request(2'd3, 4'd1, 4'd12);
    expect_out("pop_range_err", 4'd0, 4'd0, FBusy | FErr);
    step();
    request(2'd0, 4'd2, 4'd0);
    expect_out("mov_zero_err", 4'd0, 4'd0, FBusy | FErr);
    step();
    expect_out("err_idle", 4'd0, 4'd0, FNone);

    // Reset during PW abandons the push
    request(2'd2, 4'd3, 4'd1);
    step();
    expect_out("pw_pre_rst", 4'd3, 4'd0, FBusy | FMemWr);
    r = 1'b0;
    step();
    expect_out("mid_rst", 4'd0, 4'd0, FNone);
    r = 1'b1;
    step();
    expect_out("post_rst", 4'd0, 4'd0, FNone);

    // MOV with src==dst after reset completes normally
    request(2'd0, 4'd11, 4'd11);
    expect_out("mov_same", 4'd11, 4'd11, FBusy);
    step();
    expect_out("mov_same_done", 4'd0, 4'd0, FBusy | FDone);
    step();
    expect_out("final_idle", 4'd0, 4'd0, FNone);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
